// File: rtl/iot_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module   : iot_byte_tx
//  Purpose  : Serialises buffered 128-bit sensor words into a back-pressured
//             MSB-first byte stream with a run-wide function select.
//  Revision : 1.0  initial release
// ============================================================================
module iot_byte_tx #(
    parameter int DEPTH     = 2,
    parameter int NUM_WORDS = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] word_data,
    input  logic         word_valid,
    output logic         word_ready,
    input  logic [2:0]   cfg_fn_sel,
    input  logic         busy,
    output logic         in_en,
    output logic [7:0]   iot_in,
    output logic [2:0]   fn_sel,
    output logic [6:0]   word_cnt,
    output logic         done
);

    localparam int                 c_ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W     = c_ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(DEPTH);
    localparam logic [6:0]         c_NUM_WORDS = 7'(NUM_WORDS);
    localparam logic [6:0]         c_LAST_WORD = 7'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [127:0]          r_mem [DEPTH];
    logic [c_ADDR_W-1:0]   r_wr_ptr;
    logic [c_ADDR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [3:0]            r_idx;

    logic                  w_push;
    logic                  w_can_emit;
    logic                  w_pop;
    logic [127:0]          w_head;
    logic [6:0]            w_msb;
    logic [7:0]            w_head_byte;

    // Readiness uses the pre-edge count, so a full FIFO refuses a write even
    // on the edge where a pop frees a slot.
    assign word_ready  = (r_count < c_DEPTH) && !done;
    assign w_push      = word_valid && word_ready;
    assign w_can_emit  = (r_state == S_SEND) && !busy && (r_count != '0);
    assign w_pop       = w_can_emit && (r_idx == 4'hF);

    assign w_head      = r_mem[r_rd_ptr];
    assign w_msb       = 7'd127 - {r_idx, 3'b000};
    assign w_head_byte = w_head[w_msb -: 8];

    // Storage carries no reset: occupancy is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= word_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= 4'd0;
            in_en    <= 1'b0;
            iot_in   <= 8'h00;
            fn_sel   <= 3'd0;
            word_cnt <= 7'd0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    in_en  <= 1'b0;
                    iot_in <= 8'h00;
                    fn_sel <= cfg_fn_sel;
                    if (r_count != '0) begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_can_emit) begin
                        in_en  <= 1'b1;
                        iot_in <= w_head_byte;
                        if (r_idx == 4'hF) begin
                            r_idx <= 4'd0;
                            if (word_cnt < c_NUM_WORDS) begin
                                word_cnt <= word_cnt + 7'd1;
                            end
                            if (word_cnt == c_LAST_WORD) begin
                                r_state <= S_DONE;
                                done    <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end else begin
                        // Busy or starved: the bus idles and the byte index holds.
                        in_en  <= 1'b0;
                        iot_in <= 8'h00;
                    end
                end
                S_DONE: begin
                    in_en  <= 1'b0;
                    iot_in <= 8'h00;
                end
                default: begin
                    r_state <= S_IDLE;
                    in_en   <= 1'b0;
                    iot_in  <= 8'h00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iot_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iot_byte_tx
//  Purpose  : Directed self-checking bench for iot_byte_tx (DEPTH=2, NUM_WORDS=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_iot_byte_tx;

    logic         clk;
    logic         rst;
    logic [127:0] word_data;
    logic         word_valid;
    logic         word_ready;
    logic [2:0]   cfg_fn_sel;
    logic         busy;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic [6:0]   word_cnt;
    logic         done;

    iot_byte_tx #(.DEPTH(2), .NUM_WORDS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .cfg_fn_sel (cfg_fn_sel),
        .busy       (busy),
        .in_en      (in_en),
        .iot_in     (iot_in),
        .fn_sel     (fn_sel),
        .word_cnt   (word_cnt),
        .done       (done)
    );

    localparam logic [127:0] c_W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] c_W2 = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    localparam logic [127:0] c_W3 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] c_W4 = 128'h10203040_50607080_90A0B0C0_D0E0F000;
    localparam logic [127:0] c_W5 = 128'hDEADBEEF_CAFEBABE_0BADF00D_12345678;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          viol     = 0;
    logic        busy_s   = 1'b0;
    logic [7:0]  q_bytes [$];
    int          q_stamp [$];
    logic [7:0]  exp_q   [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        busy_s <= busy;
    end

    // Byte monitor: every strobed byte, its cycle, and any strobe under busy.
    always @(negedge clk) begin
        if (!rst && in_en) begin
            q_bytes.push_back(iot_in);
            q_stamp.push_back(cyc);
            if (busy_s) viol++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] w, input int i);
        logic [127:0] t;
        t = w << (8 * i);
        return t[127:120];
    endfunction

    task automatic add_word(input logic [127:0] w);
        for (int i = 0; i < 16; i++) exp_q.push_back(byte_of(w, i));
    endtask

    task automatic clear_streams();
        q_bytes.delete();
        q_stamp.delete();
        exp_q.delete();
    endtask

    task automatic push_word(input logic [127:0] w);
        int t = 0;
        word_data  = w;
        word_valid = 1'b1;
        while (!word_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("push_timeout", 128'(t), 128'(0));
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int t = 0;
        while (q_bytes.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_count"}, 128'(q_bytes.size()), 128'(n));
    endtask

    task automatic wait_for_byte(input string tag, input logic [7:0] val, input int budget);
        int   t = 0;
        logic found = 1'b0;
        while (!found && t < budget) begin
            @(negedge clk);
            t++;
            if (in_en === 1'b1 && iot_in === val) found = 1'b1;
        end
        check(tag, 128'(found), 128'(1));
    endtask

    task automatic check_stream(input string tag, input bit contiguous);
        check({tag, "_len"}, 128'(q_bytes.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < q_bytes.size())
                check($sformatf("%s_b%0d", tag, i), 128'(q_bytes[i]), 128'(exp_q[i]));
        end
        if (contiguous && q_stamp.size() == exp_q.size() && exp_q.size() > 0)
            check({tag, "_contig"}, 128'(q_stamp[q_stamp.size()-1] - q_stamp[0]),
                  128'(exp_q.size() - 1));
    endtask

    initial begin
        rst        = 1'b1;
        word_data  = '0;
        word_valid = 1'b0;
        cfg_fn_sel = 3'd0;
        busy       = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_en",  128'(in_en),      128'(0));
        check("rst_iot_in", 128'(iot_in),     128'(0));
        check("rst_fn_sel", 128'(fn_sel),     128'(0));
        check("rst_wcnt",   128'(word_cnt),   128'(0));
        check("rst_done",   128'(done),       128'(0));
        check("rst_ready",  128'(word_ready), 128'(1));
        rst = 1'b0;
        @(negedge clk);

        // Single word, no back-pressure, idle latency of two edges
        clear_streams();
        add_word(c_W0);
        push_word(c_W0);
        check("lat_n0", 128'(in_en), 128'(0));
        @(negedge clk);
        check("lat_n1", 128'(in_en), 128'(0));
        @(negedge clk);
        check("lat_n2_en",   128'(in_en),  128'(1));
        check("lat_n2_byte", 128'(iot_in), 128'(8'h00));
        wait_bytes("single", 16, 40);
        check_stream("single", 1'b1);
        check("single_wcnt", 128'(word_cnt), 128'(1));
        @(negedge clk);
        check("single_idle", 128'(in_en), 128'(0));

        // Busy for three edges right after byte 5
        clear_streams();
        add_word(c_W0);
        push_word(c_W0);
        wait_for_byte("busy_see55", 8'h55, 40);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("busy_hold%0d_en", i),   128'(in_en),  128'(0));
            check($sformatf("busy_hold%0d_byte", i), 128'(iot_in), 128'(0));
        end
        busy = 1'b0;
        @(negedge clk);
        check("busy_resume_en",   128'(in_en),  128'(1));
        check("busy_resume_byte", 128'(iot_in), 128'(8'h66));
        wait_bytes("busy", 16, 40);
        check_stream("busy", 1'b0);
        check("busy_wcnt", 128'(word_cnt), 128'(2));

        // Reset while byte 9 is on the bus
        clear_streams();
        push_word(c_W0);
        wait_for_byte("mid_see99", 8'h99, 40);
        rst = 1'b1;
        #1;
        check("mid_rst_en",    128'(in_en),      128'(0));
        check("mid_rst_byte",  128'(iot_in),     128'(0));
        check("mid_rst_wcnt",  128'(word_cnt),   128'(0));
        check("mid_rst_ready", 128'(word_ready), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("mid_quiet%0d", i), 128'(in_en), 128'(0));
        end
        clear_streams();
        add_word(c_W2);
        push_word(c_W2);
        @(negedge clk);
        @(negedge clk);
        check("mid_restart_en",   128'(in_en),  128'(1));
        check("mid_restart_byte", 128'(iot_in), 128'(8'hA0));
        wait_bytes("mid", 16, 40);
        check_stream("mid", 1'b1);
        check("mid_wcnt", 128'(word_cnt), 128'(1));

        // Back-to-back three words with valid held high
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_streams();
        add_word(c_W3);
        add_word(c_W4);
        add_word(c_W5);
        push_word(c_W3);
        push_word(c_W4);
        word_valid = 1'b1;
        word_data  = c_W5;
        check("b2b_full_ready", 128'(word_ready), 128'(0));
        push_word(c_W5);
        wait_bytes("b2b", 48, 120);
        check_stream("b2b", 1'b1);
        check("b2b_wcnt", 128'(word_cnt), 128'(3));
        check("b2b_done", 128'(done),     128'(0));

        // Full run of NUM_WORDS=4 with fn_sel frozen and done at the last byte
        rst        = 1'b1;
        cfg_fn_sel = 3'd3;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_streams();
        add_word(c_W3);
        add_word(c_W4);
        add_word(c_W5);
        add_word(c_W2);
        push_word(c_W3);
        push_word(c_W4);
        cfg_fn_sel = 3'd5;
        check("run_fn_sel_early", 128'(fn_sel), 128'(3));
        push_word(c_W5);
        push_word(c_W2);
        begin
            int t = 0;
            while (done !== 1'b1 && t < 120) begin
                @(negedge clk);
                t++;
            end
        end
        check("run_done",      128'(done),     128'(1));
        check("run_done_en",   128'(in_en),    128'(1));
        check("run_done_byte", 128'(iot_in),   128'(8'hAF));
        check("run_done_wcnt", 128'(word_cnt), 128'(4));
        check("run_fn_sel",    128'(fn_sel),   128'(3));
        word_data  = c_W0;
        word_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("post_ready%0d", i), 128'(word_ready), 128'(0));
            check($sformatf("post_en%0d", i),    128'(in_en),      128'(0));
            check($sformatf("post_wcnt%0d", i),  128'(word_cnt),   128'(4));
        end
        word_valid = 1'b0;
        check("post_done",   128'(done),   128'(1));
        check("post_fn_sel", 128'(fn_sel), 128'(3));
        check_stream("run", 1'b1);
        check("busy_strobe_viol", 128'(viol), 128'(0));

        rst = 1'b1;
        #1;
        check("final_rst_done",  128'(done),       128'(0));
        check("final_rst_ready", 128'(word_ready), 128'(1));
        check("final_rst_fn",    128'(fn_sel),     128'(0));
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iot_byte_tx.md
Name: iot_byte_tx

Overview:
- Source-side serializer for the IOTDF byte-stream input interface.
- Accepts 128-bit sensor words from an upstream valid/ready port and buffers them in a small FIFO.
- Emits each word as 16 bytes, MSB byte first, on iot_in/in_en, honouring the consumer's busy back-pressure.
- Drives a stable fn_sel for the whole run and flags completion after NUM_WORDS words; this is the transmitter end of the interface IOTDF receives.

Parameters:
- DEPTH, 2, word FIFO entries (power of two, >=2).
- NUM_WORDS, 60, words per run; done asserts after the last byte of word NUM_WORDS-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- word_data  input  128  upstream word, bits [127:120] sent first.
- word_valid  input  1  upstream word available.
- word_ready  output  1  FIFO can accept a word this cycle (combinational from FIFO count).
- cfg_fn_sel  input  3  requested function, sampled at run start.
- busy  input  1  consumer back-pressure, sampled at rising edge.
- in_en  output  1  registered byte strobe.
- iot_in  output  8  registered byte.
- fn_sel  output  3  registered function select, constant for the run.
- word_cnt  output  7  words fully transmitted, saturates at NUM_WORDS.
- done  output  1  sticky run-complete flag.

Behaviour:
- Reset (async, immediate), all outputs and state:
  - in_en=0, iot_in=8'h00, fn_sel=3'd0, word_cnt=0, done=0.
  - FIFO emptied, byte index=0, state=IDLE.
  - Reset mid-word abandons the word; no partial bytes are emitted after reset releases.
- FIFO write: a word is written when word_valid && word_ready at a rising edge.
  - word_ready = (count<DEPTH) && !done.
  - Simultaneous write and pop on a full FIFO is allowed: the pop frees the slot in the same edge. word_ready still reflects the pre-edge count, so the write is refused that cycle.
- States:
  - IDLE: fn_sel<=cfg_fn_sel every cycle. Go to SEND when the FIFO is non-empty.
  - SEND: per rising edge, judged on the sampled busy:
    - busy==0 and a head word exists: iot_in<=head[127-8*idx -: 8], in_en<=1, idx<=idx+1.
    - busy==1: in_en<=0, iot_in<=0, idx held. The byte already on the bus at that edge counts as accepted.
    - FIFO empty between words (idx==0): in_en<=0, iot_in<=0, stay in SEND; no gap in the byte order.
    - On emitting byte 15: pop FIFO, idx<=0, word_cnt<=word_cnt+1.
    - If that is word NUM_WORDS-1, go to DONE and set done<=1 on the same edge.
  - DONE: in_en=0, iot_in=0, word_ready=0. Remain until rst.
- fn_sel is frozen from leaving IDLE until reset.
- in_en is never asserted in an edge where sampled busy==1.
- Latency: word written at edge N reaches in_en=1 with byte 0 at edge N+2 (idle, busy low); then one byte per cycle while busy stays low.
- Throughput: 16 cycles/word with no back-pressure; FIFO refills overlap with transmission.
- Byte index is 4 bits, wrapping 15->0 only on pop. word_cnt never exceeds NUM_WORDS.

Test Plan:
- Single word 128'h00112233_44556677_8899AABB_CCDDEEFF, busy=0:
  - Expect in_en high 16 consecutive cycles with iot_in 00,11,22,...,FF.
  - Expect word_cnt=1 after the last byte.
- busy pulses high 3 cycles after byte 5 (8'h55) is emitted:
  - Expect in_en=0 for exactly the busy-sampled edges.
  - Expect resume with 8'h66; no byte is duplicated or dropped.
- Back-to-back 3 words with word_valid held high, DEPTH=2:
  - Expect word_ready low once the FIFO is full.
  - Expect 48 contiguous bytes and word_cnt=3.
- NUM_WORDS=4 run, cfg_fn_sel=3 then changed to 5 mid-run:
  - Expect fn_sel stays 3.
  - Expect done rises on the edge emitting byte 15 of word 3; word_ready=0 afterwards.
  - Expect extra word_valid to be ignored.
- Assert rst while emitting byte 9 of a word:
  - Expect immediate in_en=0, iot_in=0, word_cnt=0, FIFO empty.
  - Expect the next word after release to start at its byte 0.
